uart_rx_buffered: RTL and testbench

UART_RX_BUFFERED -- requirements
Module: uart_rx_buffered

---
 rtl/uart_rx_pkg.sv | 23 ++
 rtl/uart_rx_fifo.sv | 60 ++++++
 rtl/uart_rx_buffered.sv | 170 +++++++++++++++++
 tb/tb_uart_rx_buffered.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_rx_pkg.sv
// Shared types for the buffered UART receiver: FSM states, parity modes,
// and the width of one FIFO entry ({data, parity_err, frame_err}).
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } rx_state_e;

  typedef enum logic [1:0] {
    PAR_NONE = 2'd0,
    PAR_EVEN = 2'd1,
    PAR_ODD  = 2'd2
  } parity_mode_e;

  function automatic int entry_width(input int data_bits);
    return data_bits + 2;
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// Synchronous FIFO for received frames. A pop and a push in the same cycle
// both take effect, even when full; the head reads as zero while empty.
module uart_rx_fifo #(
  parameter int WIDTH = 10,
  parameter int DEPTH = 8
) (
  input  logic                     clk_in,
  input  logic                     reset,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] DEPTH_L = DEPTH[AW:0];

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]      level_q, level_d;
  logic             do_push, do_pop;

  assign empty   = (level_q == '0);
  assign full    = (level_q == DEPTH_L);
  assign level   = level_q;
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);
  assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

  // Pointers wrap naturally because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    if (do_push && !do_pop)      level_d = level_q + 1'b1;
    else if (do_pop && !do_push) level_d = level_q - 1'b1;
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clk_in) begin
    if (do_push) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_rx_buffered.sv
// Oversampling UART receiver with optional parity, 1/2 stop bits and a
// receive FIFO; break frames are stored and re-arming waits for idle-high.
module uart_rx_buffered
  import uart_rx_pkg::*;
#(
  parameter int DATA_BITS   = 8,
  parameter int PARITY_MODE = 0,
  parameter int STOP_BITS   = 1,
  parameter int OVERSAMPLE  = 16,
  parameter int FIFO_DEPTH  = 8,
  parameter int DIV_WIDTH   = 16
) (
  input  logic                          clk_in,
  input  logic                          reset,
  input  logic                          uart_rx,
  input  logic                          rx_en,
  input  logic [DIV_WIDTH-1:0]          clk_div,
  output logic [DATA_BITS-1:0]          rx_data,
  output logic                          rx_parity_err,
  output logic                          rx_frame_err,
  output logic                          rx_valid,
  input  logic                          rx_ready,
  output logic                          overrun,
  input  logic                          clr_overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
  output logic                          busy,
  output rx_state_e                     dbg_state
);

  localparam int EW = entry_width(DATA_BITS);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF_M1   = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] FULL_M1   = TW'(OVERSAMPLE - 1);
  localparam logic [3:0]    BIT_LAST  = 4'(DATA_BITS - 1);
  localparam logic [3:0]    STOP_LAST = 4'(STOP_BITS - 1);
  localparam parity_mode_e  PMODE     = parity_mode_e'(PARITY_MODE[1:0]);

  logic rx_meta_q, rx_meta_d, rx_sync_q, rx_sync_d, rx_prev_q, rx_prev_d;
  logic [DIV_WIDTH-1:0] div_q, div_d, cnt_q, cnt_d;
  logic overrun_q, overrun_d;
  logic tick, start_det, stop_err, push;
  logic fifo_full, fifo_empty;
  logic [EW-1:0] push_entry, head_entry;

  rx_state_e            state_q;
  logic [TW-1:0]        os_q;
  logic [3:0]           bit_q;
  logic [DATA_BITS-1:0] shift_q;
  logic                 par_err_q, frame_err_q, wait_high_q;

  assign tick       = (cnt_q == div_q);
  assign start_det  = (state_q == ST_IDLE) && rx_en && !wait_high_q && rx_prev_q && !rx_sync_q;
  assign stop_err   = frame_err_q | ~rx_sync_q;
  assign push       = (state_q == ST_STOP) && tick && (os_q == FULL_M1) && (bit_q == STOP_LAST);
  assign push_entry = {shift_q, par_err_q, stop_err};

  // The divisor is latched at start detection so a frame sees one bit rate.
  always_comb begin
    rx_meta_d = uart_rx;
    rx_sync_d = rx_meta_q;
    rx_prev_d = rx_sync_q;
    div_d     = div_q;
    cnt_d     = cnt_q + 1'b1;
    if (start_det) begin
      div_d = clk_div;
      cnt_d = '0;
    end else if (tick) begin
      cnt_d = '0;
    end
    overrun_d = (overrun_q & ~clr_overrun) | (push & fifo_full & ~(rx_ready & ~fifo_empty));
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      rx_meta_q <= 1'b1;
      rx_sync_q <= 1'b1;
      rx_prev_q <= 1'b1;
      div_q     <= '0;
      cnt_q     <= '0;
      overrun_q <= 1'b0;
    end else begin
      rx_meta_q <= rx_meta_d;
      rx_sync_q <= rx_sync_d;
      rx_prev_q <= rx_prev_d;
      div_q     <= div_d;
      cnt_q     <= cnt_d;
      overrun_q <= overrun_d;
    end
  end

  always_ff @(posedge clk_in or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      os_q        <= '0;
      bit_q       <= '0;
      shift_q     <= '0;
      par_err_q   <= 1'b0;
      frame_err_q <= 1'b0;
      wait_high_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (rx_sync_q) wait_high_q <= 1'b0;
          if (start_det) begin
            state_q     <= ST_START;
            os_q        <= '0;
            bit_q       <= '0;
            par_err_q   <= 1'b0;
            frame_err_q <= 1'b0;
          end
        end
        ST_START: if (tick) begin
          if (os_q == HALF_M1) begin
            os_q    <= '0;
            state_q <= rx_sync_q ? ST_IDLE : ST_DATA;
          end else os_q <= os_q + 1'b1;
        end
        ST_DATA: if (tick) begin
          if (os_q == FULL_M1) begin
            os_q    <= '0;
            shift_q <= {rx_sync_q, shift_q[DATA_BITS-1:1]};
            if (bit_q == BIT_LAST) begin
              bit_q   <= '0;
              state_q <= (PMODE == PAR_NONE) ? ST_STOP : ST_PARITY;
            end else bit_q <= bit_q + 1'b1;
          end else os_q <= os_q + 1'b1;
        end
        ST_PARITY: if (tick) begin
          if (os_q == FULL_M1) begin
            os_q      <= '0;
            par_err_q <= ((rx_sync_q ^ (^shift_q)) != (PMODE == PAR_ODD));
            state_q   <= ST_STOP;
          end else os_q <= os_q + 1'b1;
        end
        ST_STOP: if (tick) begin
          if (os_q == FULL_M1) begin
            os_q        <= '0;
            frame_err_q <= stop_err;
            if (bit_q == STOP_LAST) begin
              state_q     <= ST_IDLE;
              wait_high_q <= stop_err && (shift_q == '0);
            end else bit_q <= bit_q + 1'b1;
          end else os_q <= os_q + 1'b1;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // rx_valid/rx_ready: the head entry transfers on a clk_in edge where both
  // are high; until then rx_valid stays high and the head is held stable.
  uart_rx_fifo #(.WIDTH(EW), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_in  (clk_in),
    .reset   (reset),
    .push    (push),
    .wr_data (push_entry),
    .pop     (rx_ready),
    .rd_data (head_entry),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fifo_level)
  );

  assign {rx_data, rx_parity_err, rx_frame_err} = head_entry;
  assign rx_valid  = ~fifo_empty;
  assign overrun   = overrun_q;
  assign busy      = (state_q != ST_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_rx_buffered.sv
// Directed bench: 8N1 receiver (a) and even-parity receiver (b), checked
// against hand-computed entries held in an expected queue.
`timescale 1ns/1ps
module tb_uart_rx_buffered;
  import uart_rx_pkg::*;

  localparam int DB = 8;
  localparam int EW = DB + 2;
  localparam int LW = 4;

  // clock / reset
  logic clk_in = 1'b0;
  logic reset;
  always #5 clk_in = ~clk_in;

  logic          line_a, line_b, rx_en, clr_overrun;
  logic          rx_ready_a, rx_ready_b;
  logic [15:0]   clk_div;
  logic [DB-1:0] rx_data_a, rx_data_b;
  logic          perr_a, ferr_a, valid_a, ovr_a, busy_a;
  logic          perr_b, ferr_b, valid_b, ovr_b, busy_b;
  logic [LW-1:0] level_a, level_b;
  logic [2:0]    state_a, state_b;

  int vec_cnt = 0;
  int err_cnt = 0;
  int bc;
  logic [EW-1:0] exp_q[$];

  uart_rx_buffered dut (
    .clk_in(clk_in), .reset(reset), .uart_rx(line_a), .rx_en(rx_en), .clk_div(clk_div),
    .rx_data(rx_data_a), .rx_parity_err(perr_a), .rx_frame_err(ferr_a), .rx_valid(valid_a),
    .rx_ready(rx_ready_a), .overrun(ovr_a), .clr_overrun(clr_overrun), .fifo_level(level_a),
    .busy(busy_a), .dbg_state(state_a)
  );

  uart_rx_buffered #(.PARITY_MODE(1)) dut_par (
    .clk_in(clk_in), .reset(reset), .uart_rx(line_b), .rx_en(rx_en), .clk_div(clk_div),
    .rx_data(rx_data_b), .rx_parity_err(perr_b), .rx_frame_err(ferr_b), .rx_valid(valid_b),
    .rx_ready(rx_ready_b), .overrun(ovr_b), .clr_overrun(clr_overrun), .fifo_level(level_b),
    .busy(busy_b), .dbg_state(state_b)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // driver tasks: all drives happen on the falling edge
  task automatic drive_bit(input logic sel, input logic v, input int cycles);
    if (sel) line_b = v;
    else     line_a = v;
    repeat (cycles) @(negedge clk_in);
  endtask

  task automatic send_frame(input logic sel, input logic [7:0] d, input logic use_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(sel, 1'b0, bc);
    for (int i = 0; i < 8; i++) drive_bit(sel, d[i], bc);
    if (use_par) drive_bit(sel, par_bit, bc);
    drive_bit(sel, stop_bit, bc);
  endtask

  // scoreboard: compare head of receiver a against the expected queue, then pop
  task automatic pop_check(input string tag);
    logic [EW-1:0] exp_e;
    int n;
    n = 0;
    while (!valid_a && n < 3000) begin
      @(negedge clk_in);
      n++;
    end
    check({tag, "_valid"}, valid_a, 1);
    exp_e = exp_q.pop_front();
    check(tag, {rx_data_a, perr_a, ferr_a}, exp_e);
    rx_ready_a = 1'b1;
    @(negedge clk_in);
    rx_ready_a = 1'b0;
  endtask

  initial begin
    #600us;
    $display("FAIL watchdog: simulation did not complete, got timeout, expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1; line_a = 1'b1; line_b = 1'b1; rx_en = 1'b1;
    rx_ready_a = 1'b0; rx_ready_b = 1'b0; clr_overrun = 1'b0;
    clk_div = 16'd5;
    bc = (5 + 1) * 16;
    repeat (3) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);

    check("rst_valid", valid_a, 0);
    check("rst_data",  rx_data_a, 0);
    check("rst_perr",  perr_a, 0);
    check("rst_ferr",  ferr_a, 0);
    check("rst_ovr",   ovr_a, 0);
    check("rst_level", level_a, 0);
    check("rst_busy",  busy_a, 0);
    check("rst_state", state_a, ST_IDLE);

    // 8N1 0xA5, 96-cycle bit period
    exp_q.push_back({8'hA5, 2'b00});
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    check("a5_level", level_a, 1);
    pop_check("a5");
    check("a5_level_after", level_a, 0);

    // stop bit low, then a clean frame
    exp_q.push_back({8'h3C, 2'b01});
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b1, bc);
    exp_q.push_back({8'h55, 2'b00});
    send_frame(1'b0, 8'h55, 1'b0, 1'b0, 1'b1);
    pop_check("ferr_3c");
    pop_check("clean_55");

    // break: all-zero frame with low stop, line held low, then released
    exp_q.push_back({8'h00, 2'b01});
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    drive_bit(1'b0, 1'b0, 2 * bc);
    check("break_level", level_a, 1);
    drive_bit(1'b0, 1'b1, bc);
    exp_q.push_back({8'h5A, 2'b00});
    send_frame(1'b0, 8'h5A, 1'b0, 1'b0, 1'b1);
    check("after_break_level", level_a, 2);
    pop_check("break_00");
    pop_check("after_break_5a");

    // even parity on 0x07: wrong parity bit then correct one
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    check("par_bad_valid", valid_b, 1);
    check("par_bad_entry", {rx_data_b, perr_b, ferr_b}, {8'h07, 2'b10});
    rx_ready_b = 1'b1; @(negedge clk_in); rx_ready_b = 1'b0;
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    check("par_ok_valid", valid_b, 1);
    check("par_ok_entry", {rx_data_b, perr_b, ferr_b}, {8'h07, 2'b00});
    rx_ready_b = 1'b1; @(negedge clk_in); rx_ready_b = 1'b0;
    check("par_level", level_b, 0);

    // fill to 8, ninth frame overruns
    for (int i = 0; i < 8; i++) begin
      exp_q.push_back({8'(i), 2'b00});
      send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
    end
    check("full_level", level_a, 8);
    check("full_ovr", ovr_a, 0);
    send_frame(1'b0, 8'h08, 1'b0, 1'b0, 1'b1);
    check("ovr_level", level_a, 8);
    check("ovr_flag", ovr_a, 1);
    for (int i = 0; i < 8; i++) pop_check($sformatf("drain%0d", i));
    check("drain_valid", valid_a, 0);
    check("drain_level", level_a, 0);
    check("ovr_sticky", ovr_a, 1);
    clr_overrun = 1'b1; @(negedge clk_in); clr_overrun = 1'b0;
    check("ovr_clr", ovr_a, 0);

    // 3-tick low glitch on idle line
    line_a = 1'b0;
    repeat (6) @(negedge clk_in);
    check("glitch_busy_start", busy_a, 1);
    repeat (12) @(negedge clk_in);
    line_a = 1'b1;
    repeat (27) @(negedge clk_in);
    check("glitch_busy_window", busy_a, 1);
    repeat (15) @(negedge clk_in);
    check("glitch_busy_end", busy_a, 0);
    check("glitch_level", level_a, 0);

    // reset in data bit 4 of 0xF0, with one entry already stored
    send_frame(1'b0, 8'h33, 1'b0, 1'b0, 1'b1);
    check("pre_rst_level", level_a, 1);
    drive_bit(1'b0, 1'b0, bc);
    for (int i = 0; i < 4; i++) drive_bit(1'b0, 1'b0, bc);
    drive_bit(1'b0, 1'b1, bc / 2);
    check("pre_rst_busy", busy_a, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk_in);
    reset = 1'b0;
    @(negedge clk_in);
    check("mid_rst_valid", valid_a, 0);
    check("mid_rst_data",  rx_data_a, 0);
    check("mid_rst_perr",  perr_a, 0);
    check("mid_rst_ferr",  ferr_a, 0);
    check("mid_rst_level", level_a, 0);
    check("mid_rst_busy",  busy_a, 0);
    check("mid_rst_state", state_a, ST_IDLE);
    drive_bit(1'b0, 1'b1, bc);
    check("post_rst_level", level_a, 0);
    exp_q.push_back({8'h12, 2'b00});
    send_frame(1'b0, 8'h12, 1'b0, 1'b0, 1'b1);
    pop_check("post_rst_12");

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
